// File: rtl/hls_cnn_2d_mac_pipe_pkg.sv
// Shared types and fixed-point helpers for the CNN MAC datapath.
// Helpers work on a wide signed container so one copy serves every parameterisation.
package hls_cnn_2d_pkg;

    localparam int unsigned WIDE_W = 96;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_meta_t;

    // Clamp x to the signed range of a w-bit value.
    function automatic wide_t sat_signed(input wide_t x, input int unsigned w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = ~hi;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Half-up rounding followed by an arithmetic right shift.
    function automatic wide_t round_shift(input wide_t x, input int unsigned sh);
        if (sh == 0) return x;
        return (x + (wide_t'(1) <<< (sh - 1))) >>> sh;
    endfunction

endpackage

// File: rtl/hls_cnn_2d_mac_pipe_if.sv
// Beat input and result output bundle of the pipelined MAC.
interface hls_cnn_2d_mac_pipe_if #(
    parameter int unsigned DIN0_WIDTH = 16,
    parameter int unsigned DIN1_WIDTH = 14,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned OUT_WIDTH  = 16
) ();
    logic                         ce;
    logic                         in_valid;
    logic                         first;
    logic                         last;
    logic signed [DIN0_WIDTH-1:0] din0;
    logic signed [DIN1_WIDTH-1:0] din1;
    logic                         out_valid;
    logic signed [OUT_WIDTH-1:0]  dout;
    logic signed [ACC_WIDTH-1:0]  acc_dout;
    logic                         sat;
    logic                         acc_ovf;

    modport master (
        output ce, in_valid, first, last, din0, din1,
        input  out_valid, dout, acc_dout, sat, acc_ovf
    );

    modport slave (
        input  ce, in_valid, first, last, din0, din1,
        output out_valid, dout, acc_dout, sat, acc_ovf
    );
endinterface

// File: rtl/hls_cnn_2d_mul_pipe.sv
// Signed multiplier with NUM_STAGE clock-enabled register stages;
// beat markers travel alongside the product.
module hls_cnn_2d_mul_pipe
    import hls_cnn_2d_pkg::*;
#(
    parameter  int unsigned DIN0_WIDTH = 16,
    parameter  int unsigned DIN1_WIDTH = 14,
    parameter  int unsigned NUM_STAGE  = 2,
    localparam int unsigned PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         ce_i,
    input  beat_meta_t                   meta_i,
    input  logic signed [DIN0_WIDTH-1:0] din0_i,
    input  logic signed [DIN1_WIDTH-1:0] din1_i,
    output logic signed [PROD_WIDTH-1:0] prod_o,
    output beat_meta_t                   meta_o
);
    logic signed [PROD_WIDTH-1:0] prod_q [NUM_STAGE];
    beat_meta_t                   meta_q [NUM_STAGE];
    logic signed [PROD_WIDTH-1:0] prod_d;

    always_comb prod_d = PROD_WIDTH'(din0_i) * PROD_WIDTH'(din1_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_STAGE; i++) begin
                prod_q[i] <= '0;
                meta_q[i] <= '0;
            end
        end else if (ce_i) begin
            prod_q[0] <= prod_d;
            meta_q[0] <= meta_i;
            for (int unsigned i = 1; i < NUM_STAGE; i++) begin
                prod_q[i] <= prod_q[i-1];
                meta_q[i] <= meta_q[i-1];
            end
        end
    end

    assign prod_o = prod_q[NUM_STAGE-1];
    assign meta_o = meta_q[NUM_STAGE-1];
endmodule

// File: rtl/hls_cnn_2d_mac_pipe.sv
// Pipelined signed MAC: one framed dot product per first..last run,
// with saturating accumulation and round-and-saturate output.
module hls_cnn_2d_mac_pipe
    import hls_cnn_2d_pkg::*;
#(
    parameter int unsigned DIN0_WIDTH = 16,
    parameter int unsigned DIN1_WIDTH = 14,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned FRAC_SHIFT = 10,
    parameter int unsigned NUM_STAGE  = 2
) (
    input logic             ap_clk,
    input logic             ap_rst,
    hls_cnn_2d_mac_pipe_if.slave bus
);
    localparam int unsigned PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

    beat_meta_t                   meta_in;
    beat_meta_t                   meta_mul;
    logic signed [PROD_WIDTH-1:0] prod;

    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         ovf_q, ovf_d;
    logic                         out_valid_q;
    logic signed [OUT_WIDTH-1:0]  dout_q, dout_d;
    logic signed [ACC_WIDTH-1:0]  acc_dout_q;
    logic                         sat_q, sat_d;
    logic                         acc_ovf_q;

    wide_t base_w, sum_w, acc_sat_w, rnd_w, out_sat_w;

    always_comb begin
        meta_in.valid = bus.in_valid;
        meta_in.first = bus.first;
        meta_in.last  = bus.last;
    end

    hls_cnn_2d_mul_pipe #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .NUM_STAGE  (NUM_STAGE)
    ) u_mul (
        .clk_i  (ap_clk),
        .rst_i  (ap_rst),
        .ce_i   (bus.ce),
        .meta_i (meta_in),
        .din0_i (bus.din0),
        .din1_i (bus.din1),
        .prod_o (prod),
        .meta_o (meta_mul)
    );

    // first restarts both the sum and the overflow sticky before this beat lands.
    always_comb begin
        base_w    = meta_mul.first ? '0 : wide_t'(acc_q);
        sum_w     = base_w + wide_t'(prod);
        acc_sat_w = sat_signed(sum_w, ACC_WIDTH);
        acc_d     = acc_sat_w[ACC_WIDTH-1:0];
        ovf_d     = (ovf_q & ~meta_mul.first) | (acc_sat_w != sum_w);
        rnd_w     = round_shift(acc_sat_w, FRAC_SHIFT);
        out_sat_w = sat_signed(rnd_w, OUT_WIDTH);
        dout_d    = out_sat_w[OUT_WIDTH-1:0];
        sat_d     = (out_sat_w != rnd_w);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            acc_dout_q  <= '0;
            sat_q       <= 1'b0;
            acc_ovf_q   <= 1'b0;
        end else if (bus.ce) begin
            out_valid_q <= 1'b0;
            if (meta_mul.valid) begin
                acc_q <= acc_d;
                ovf_q <= ovf_d;
                if (meta_mul.last) begin
                    out_valid_q <= 1'b1;
                    acc_dout_q  <= acc_d;
                    dout_q      <= dout_d;
                    sat_q       <= sat_d;
                    acc_ovf_q   <= ovf_d;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.acc_dout  = acc_dout_q;
    assign bus.sat       = sat_q;
    assign bus.acc_ovf   = acc_ovf_q;
endmodule

// File: doc/hls_cnn_2d_mac_pipe.md
Name: hls_cnn_2d_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit for the CNN convolution and dense datapaths.
- Successor to the fixed-width combinational signed multipliers. Adds configurable multiplier pipeline depth, clock-enable stalling and dot-product accumulation framed by first/last beat markers.
- Adds fixed-point round-and-saturate output with overflow flags.
- One instance computes one output-channel dot product per frame.

Parameters:
- DIN0_WIDTH, 16, signed width of din0 (activation)
- DIN1_WIDTH, 14, signed width of din1 (weight)
- ACC_WIDTH, 40, signed accumulator width; must be >= DIN0_WIDTH+DIN1_WIDTH
- OUT_WIDTH, 16, signed result width; must be <= ACC_WIDTH-FRAC_SHIFT
- FRAC_SHIFT, 10, right shift applied at output, 0..ACC_WIDTH-1
- NUM_STAGE, 2, multiplier pipeline register stages, >= 1

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst  in  1  synchronous, active-high reset
- ce  in  1  clock enable; 0 freezes all state
- in_valid  in  1  din0/din1/first/last carry a beat
- first  in  1  beat starts a new accumulation
- last  in  1  beat ends the accumulation
- din0  in  DIN0_WIDTH  signed operand
- din1  in  DIN1_WIDTH  signed operand
- out_valid  out  1  result strobe
- dout  out  OUT_WIDTH  rounded, saturated result
- acc_dout  out  ACC_WIDTH  raw accumulator value at last beat
- sat  out  1  dout was clipped in this result
- acc_ovf  out  1  accumulator saturated at least once during this frame

Behaviour:
- Reset (ap_rst=1 at an edge, regardless of ce): all pipeline valids, accumulator, ovf sticky and every output go to 0. Reset mid-frame discards the partial sum.
- ce=0: no register changes. Outputs hold, including out_valid=1 if it was high.
- Beat sampling: a beat is sampled on an edge with ce=1 and in_valid=1. Its product din0*din1 (full DIN0_WIDTH+DIN1_WIDTH signed) enters stage 1. first, last and valid travel alongside through NUM_STAGE stages.
- Accumulate stage, on the ce edge after a product exits stage NUM_STAGE with valid=1:
  - acc_next = (first ? 0 : acc) + sign_extend(product).
  - acc_next is saturated to the ACC_WIDTH signed range; the ovf sticky bit is set if clipping occurred.
  - first clears the ovf sticky before this beat's update.
- Output on a last beat, at the same edge: register out_valid=1, acc_dout=acc_next, acc_ovf=sticky.
  - Rounding is half-up: r = (acc_next + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, arithmetic shift; no addend when FRAC_SHIFT=0.
  - dout = r clipped to the OUT_WIDTH signed range; sat=1 if clipped.
- Latency: last beat sampled at ce edge t gives out_valid high after ce edge t+NUM_STAGE. out_valid stays high for exactly one ce-enabled cycle, then clears unless another last beat arrives.
- Bubbles: in_valid=0 beats do not alter acc.
- first and last on the same beat: single-product result.
- first without a preceding last: the previous partial sum is discarded silently.
- Beat without first after a last: continues from the previous acc. Legal, used for split frames.
- Back-to-back frames: last at beat n and first at beat n+1 give full throughput of one beat per ce cycle, with no dead cycle.
- acc_dout, dout, sat and acc_ovf change only when out_valid is asserted.

Decomposition:
- Shared package hls_cnn_2d_pkg holds:
  - the sat_signed and round_shift functions;
  - a beat_meta_t struct {valid, first, last}.
- Natural sub-module: hls_cnn_2d_mul_pipe, the signed multiplier with NUM_STAGE ce-gated stages carrying beat_meta_t.
- Accumulate and output logic stays in the top module.

Test Plan (defaults; NUM_STAGE=2 unless stated):
- Single beat: first=last=1, din0=1024, din1=3 -> after 2 ce edges out_valid=1, acc_dout=3072, dout=3, sat=0.
- Dot product of 4 beats: (100,200), (-50,40), (300,-10), (7,7) -> acc_dout=15049, dout=15.
- Negative rounding: first=last=1, din0=-512, din1=3 -> acc_dout=-1536, dout=-1.
- Negative half: din0=-512, din1=1 -> acc_dout=-512, dout=0.
- Saturation: din0=-32768, din1=-8192, 1 beat -> acc_dout=268435456, dout=32767, sat=1, acc_ovf=0.
  - With ACC_WIDTH=30, sum 2 such beats -> acc_dout=536870911, acc_ovf=1.
  - A following first frame -> acc_ovf=0.
- Stall and reset:
  - ce=0 for 3 cycles mid-frame in the 4-beat test -> same result, out_valid 3 cycles later, held high during the stall.
  - ap_rst pulse after 2 beats, then a fresh first=last frame (5,5) -> acc_dout=25, all outputs 0 during reset.
  - Repeat the single-beat case with NUM_STAGE=1 and 4 -> latency 1 and 4 ce edges.
